// File: rtl/multi_blink_pkg.sv
// Shared definitions for the multi-channel blink generator: mode
// constants and the per-channel state encoding.
package multi_blink_pkg;

    // Channel mode, sampled when a channel leaves IDLE
    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

    // Per-channel state: idle, output-high phase, output-low phase
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_HI = 2'd1,
        RUN_LO = 2'd2
    } ch_state_t;

endpackage

// File: rtl/blink_channel.sv
// One blink channel: a square wave in continuous mode, or a counted
// burst of high pulses in burst mode. Every output comes from its own flop.
module blink_channel
    import multi_blink_pkg::*;
#(
    parameter int CNT_W   = 24,
    parameter int BURST_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic               i_mode,
    input  logic               i_start,
    input  logic [CNT_W-1:0]   i_half_period,
    input  logic [BURST_W-1:0] i_burst_len,
    output logic               o_toggle,
    output logic               o_busy,
    output logic               o_done
);

    ch_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [CNT_W-1:0]   h_q,     h_d;
    logic [BURST_W-1:0] rem_q,   rem_d;
    logic               mode_q,  mode_d;
    logic               toggle_q, toggle_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic [CNT_W-1:0]   eff_h;
    logic [BURST_W-1:0] eff_n;
    logic               phase_end;

    // A zero half-period behaves as 1 and a zero burst length as 1
    always_comb begin
        eff_h = (i_half_period == '0) ? CNT_W'(1) : i_half_period;
        eff_n = (i_burst_len == '0) ? BURST_W'(1) : i_burst_len;
    end

    // The phase ends when the counter reaches the latched H-1. Equality
    // only, so the largest H never needs the counter to wrap.
    always_comb begin
        phase_end = (cnt_q == (h_q - CNT_W'(1)));
    end

    // Next-state logic: dropping enable beats everything else
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        h_d      = h_q;
        rem_d    = rem_q;
        mode_d   = mode_q;
        toggle_d = toggle_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (!i_enable) begin
            // Abort on any state. No done strobe, even on the final pulse.
            state_d  = IDLE;
            cnt_d    = '0;
            rem_d    = '0;
            toggle_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_mode == MODE_CONT) begin
                        // Continuous starts in the low phase
                        state_d  = RUN_LO;
                        cnt_d    = '0;
                        h_d      = eff_h;
                        mode_d   = MODE_CONT;
                        toggle_d = 1'b0;
                        busy_d   = 1'b1;
                    end else if (i_start) begin
                        // Burst starts high right away
                        state_d  = RUN_HI;
                        cnt_d    = '0;
                        h_d      = eff_h;
                        rem_d    = eff_n;
                        mode_d   = MODE_BURST;
                        toggle_d = 1'b1;
                        busy_d   = 1'b1;
                    end
                end

                RUN_HI: begin
                    if (phase_end) begin
                        cnt_d = '0;
                        h_d   = eff_h;
                        if (mode_q == MODE_BURST && rem_q == BURST_W'(1)) begin
                            // Last pulse ends normally
                            state_d  = IDLE;
                            rem_d    = '0;
                            toggle_d = 1'b0;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                        end else begin
                            state_d  = RUN_LO;
                            toggle_d = 1'b0;
                            if (mode_q == MODE_BURST) begin
                                rem_d = rem_q - BURST_W'(1);
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                RUN_LO: begin
                    if (phase_end) begin
                        state_d  = RUN_HI;
                        cnt_d    = '0;
                        h_d      = eff_h;
                        toggle_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    rem_d    = '0;
                    toggle_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset has priority over everything
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            h_q      <= '0;
            rem_q    <= '0;
            mode_q   <= MODE_CONT;
            toggle_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            h_q      <= h_d;
            rem_q    <= rem_d;
            mode_q   <= mode_d;
            toggle_q <= toggle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_toggle = toggle_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;

endmodule

// File: rtl/multi_blink_gen.sv
// Multi-channel blink generator: NUM_CH independent channels, each with
// its own slice of the packed half-period and burst-length buses.
module multi_blink_gen
    import multi_blink_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 24,
    parameter int BURST_W = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_CH-1:0]         i_enable,
    input  logic [NUM_CH-1:0]         i_mode,
    input  logic [NUM_CH-1:0]         i_start,
    input  logic [NUM_CH*CNT_W-1:0]   i_half_period,
    input  logic [NUM_CH*BURST_W-1:0] i_burst_len,
    output logic [NUM_CH-1:0]         o_toggle,
    output logic [NUM_CH-1:0]         o_busy,
    output logic [NUM_CH-1:0]         o_done
);

    // One channel per bit. Nothing is shared between channels.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        blink_channel #(
            .CNT_W   (CNT_W),
            .BURST_W (BURST_W)
        ) u_ch (
            .i_clk         (i_clk),
            .i_rst         (i_rst),
            .i_enable      (i_enable[gi]),
            .i_mode        (i_mode[gi]),
            .i_start       (i_start[gi]),
            .i_half_period (i_half_period[gi*CNT_W +: CNT_W]),
            .i_burst_len   (i_burst_len[gi*BURST_W +: BURST_W]),
            .o_toggle      (o_toggle[gi]),
            .o_busy        (o_busy[gi]),
            .o_done        (o_done[gi])
        );
    end

endmodule

// File: tb/tb_multi_blink_gen.sv
// Directed bench for multi_blink_gen. The expected waveforms come from
// closed-form timing formulas for each mode.
module tb_multi_blink_gen;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 24;
    localparam int BURST_W = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_CH-1:0]         enable;
    logic [NUM_CH-1:0]         mode;
    logic [NUM_CH-1:0]         start;
    logic [NUM_CH*CNT_W-1:0]   half;
    logic [NUM_CH*BURST_W-1:0] blen;
    logic [NUM_CH-1:0]         toggle;
    logic [NUM_CH-1:0]         busy;
    logic [NUM_CH-1:0]         done;

    int errors = 0;
    int checks = 0;

    multi_blink_gen #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_enable      (enable),
        .i_mode        (mode),
        .i_start       (start),
        .i_half_period (half),
        .i_burst_len   (blen),
        .o_toggle      (toggle),
        .o_busy        (busy),
        .o_done        (done)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs then show that edge's result
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Continuous channel, t edges after enable was first sampled: {toggle,busy,done}
    function automatic logic [2:0] exp_cont(input int t, input int h);
        return {((t / h) % 2 == 1), 1'b1, 1'b0};
    endfunction

    // Burst channel, t edges after start was sampled
    function automatic logic [2:0] exp_burst(input int t, input int h, input int n);
        int last;
        last = (2 * n - 1) * h;
        if (t < last)       return {((t / h) % 2 == 0), 1'b1, 1'b0};
        else if (t == last) return 3'b001;
        else                return 3'b000;
    endfunction

    task automatic chk_ch(input string tag, input int c, input logic [2:0] e);
        chk(tag, {29'd0, toggle[c], busy[c], done[c]}, {29'd0, e});
    endtask

    task automatic set_ch(input int c, input int h, input int n);
        half[c*CNT_W +: CNT_W]     = CNT_W'(h);
        blen[c*BURST_W +: BURST_W] = BURST_W'(n);
    endtask

    initial begin
        rst = 1'b1; enable = '0; mode = '0; start = '0; half = '0; blen = '0;

        // Reset state
        step(); step();
        chk("rst_toggle", {28'd0, toggle}, 32'd0);
        chk("rst_busy",   {28'd0, busy},   32'd0);
        chk("rst_done",   {28'd0, done},   32'd0);

        // Reset in the middle of a continuous run, H=3
        rst = 1'b0; set_ch(0, 3, 0); enable[0] = 1'b1;
        for (int t = 0; t < 4; t++) begin
            step();
            chk_ch($sformatf("pre_rst t=%0d", t), 0, exp_cont(t, 3));
        end
        rst = 1'b1;
        step();
        chk("midrst_all", {20'd0, toggle, busy, done}, 32'd0);
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            step();
            chk_ch($sformatf("post_rst t=%0d", t), 0, exp_cont(t, 3));
        end
        enable[0] = 1'b0;
        step();
        chk_ch("rst_disable", 0, 3'b000);

        // Continuous ch0, H=4, then drop enable during a high phase
        set_ch(0, 4, 0); enable[0] = 1'b1;
        for (int t = 0; t < 14; t++) begin
            step();
            chk_ch($sformatf("cont4 t=%0d", t), 0, exp_cont(t, 4));
        end
        enable[0] = 1'b0;
        step();
        chk_ch("cont4_drop", 0, 3'b000);

        // Burst ch1, H=2, N=3; enable without start stays idle
        set_ch(1, 2, 3); mode[1] = 1'b1; enable[1] = 1'b1;
        step();
        chk_ch("burst_nostart", 1, 3'b000);
        // Start; a second start mid-burst is ignored; a start seen on the done
        // cycle launches the next burst with no gap
        start[1] = 1'b1;
        for (int t = 0; t <= 10; t++) begin
            step();
            if (t == 0)  start[1] = 1'b0;
            if (t == 2)  start[1] = 1'b1;
            if (t == 3)  start[1] = 1'b0;
            if (t == 10) start[1] = 1'b1;
            chk_ch($sformatf("burst t=%0d", t), 1, exp_burst(t, 2, 3));
        end
        step();
        start[1] = 1'b0;
        chk_ch("b2b_start", 1, 3'b110);
        enable[1] = 1'b0;
        step();
        chk_ch("b2b_drop", 1, 3'b000);

        // H=0 acts as H=1 on ch2 (continuous)
        set_ch(2, 0, 0); enable[2] = 1'b1;
        for (int t = 0; t < 6; t++) begin
            step();
            chk_ch($sformatf("h0 t=%0d", t), 2, exp_cont(t, 1));
        end
        enable[2] = 1'b0;
        step();
        chk_ch("h0_drop", 2, 3'b000);

        // N=0 acts as N=1 on ch3 (burst, H=1)
        set_ch(3, 1, 0); mode[3] = 1'b1; enable[3] = 1'b1; start[3] = 1'b1;
        for (int t = 0; t < 3; t++) begin
            step();
            start[3] = 1'b0;
            chk_ch($sformatf("n0 t=%0d", t), 3, exp_burst(t, 1, 1));
        end
        enable[3] = 1'b0;
        step();

        // Abort: ch1 burst N=2, H=2, enable dropped during the second high phase
        set_ch(1, 2, 2); enable[1] = 1'b1; start[1] = 1'b1;
        for (int t = 0; t < 5; t++) begin
            step();
            start[1] = 1'b0;
            chk_ch($sformatf("abort t=%0d", t), 1, exp_burst(t, 2, 2));
        end
        enable[1] = 1'b0;
        step();
        chk_ch("abort_cut", 1, 3'b000);
        step();
        chk_ch("abort_nodone", 1, 3'b000);

        // Independence: all four channels at once; ch0 mode flip mid-run is ignored
        set_ch(0, 3, 0); set_ch(1, 2, 2); set_ch(2, 5, 0); set_ch(3, 1, 4);
        mode = 4'b1010; start = 4'b1010; enable = 4'b1111;
        for (int t = 0; t < 21; t++) begin
            step();
            start = '0;
            if (t == 5) mode[0] = 1'b1;
            chk_ch($sformatf("ind ch0 t=%0d", t), 0, exp_cont(t, 3));
            chk_ch($sformatf("ind ch1 t=%0d", t), 1, exp_burst(t, 2, 2));
            chk_ch($sformatf("ind ch2 t=%0d", t), 2, exp_cont(t, 5));
            chk_ch($sformatf("ind ch3 t=%0d", t), 3, exp_burst(t, 1, 4));
        end
        enable = '0;
        step();
        chk("ind_drop", {20'd0, toggle, busy, done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_blink_gen.md
# multi_blink_gen

Parametrised, multi-channel successor to the single-channel count-and-toggle block. Each channel produces either a free-running square wave or a counted burst of pulses, with a runtime-programmable half-period. It sits between the memory-game control FSM and the LED/buzzer drivers, providing sequence playback flashes and win/lose blink patterns. Per channel, it reports busy status and a one-cycle done strobe.

## Interface
Parameters:
- NUM_CH, 4, number of independent channels
- CNT_W, 24, width of half-period counter and of each i_half_period field
- BURST_W, 4, width of burst-length field

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_enable  in  NUM_CH  per-channel enable; low forces channel idle
- i_mode  in  NUM_CH  per-channel mode: 0 = continuous toggle, 1 = burst
- i_start  in  NUM_CH  per-channel burst start strobe (burst mode only)
- i_half_period  in  NUM_CH*CNT_W  per-channel half-period in cycles; channel c occupies bits [c*CNT_W +: CNT_W]
- i_burst_len  in  NUM_CH*BURST_W  per-channel high-pulse count; channel c occupies bits [c*BURST_W +: BURST_W]
- o_toggle  out  NUM_CH  channel output waveform
- o_busy  out  NUM_CH  high while channel is running (either mode)
- o_done  out  NUM_CH  one-cycle strobe when a burst completes normally

## Operation
- Each channel has three states: IDLE, RUN_HI, RUN_LO. It has a CNT_W counter, a latched half-period H, and a BURST_W remaining-pulse count.
- Effective H = max(i_half_period, 1). H is latched on entry to RUN_HI/RUN_LO from IDLE and on every phase change. A mid-phase change to i_half_period takes effect at the next phase.
- Burst length 0 is treated as 1.
- Continuous mode (i_mode=0):
  - IDLE→RUN_LO on the first edge with i_enable=1. Counter starts at 0.
  - The phase flips when counter == H-1, and the counter clears. The output period is 2H, duty is 50%.
  - o_done is never asserted in this mode.
- Burst mode (i_mode=1):
  - In IDLE, the i_start and i_enable edge enters RUN_HI with o_toggle=1 and remaining = N.
  - RUN_HI→RUN_LO after H cycles, and remaining is decremented.
  - If remaining reaches 0 at that transition, go to IDLE instead and pulse o_done.
  - RUN_LO→RUN_HI after H cycles.
- Mode is sampled on leaving IDLE. A change to i_mode while running is ignored until the channel returns to IDLE.
- i_start is ignored while busy, when i_enable=0, or in continuous mode.
- i_enable=0 in any state has two effects:
  - Next edge: IDLE, o_toggle=0, counter=0, o_busy=0.
  - No o_done, including an abort on the final pulse.
- Channels are fully independent. There is no shared counter.

## Timing
- Reset: all o_toggle=0, o_busy=0, o_done=0; all states IDLE; counters and remaining=0.
- Reset has priority over enable and start.
- Continuous mode: if i_enable is first sampled high at edge k, o_busy=1 after edge k and o_toggle rises after edge k+H. Edges then continue every H cycles.
- Burst mode: if i_start is sampled at edge k:
  - o_toggle=1 and o_busy=1 after edge k.
  - The final falling edge is at k+(2N-1)H.
  - o_done=1 for exactly the cycle after that edge, coincident with o_busy falling.
- A start on the edge immediately after o_done is accepted. There are no dead cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Counter compare is equality against H-1, so there is no overflow. With H = 2^CNT_W-1 the counter never wraps past H-1.

## Structure
- Package multi_blink_pkg: mode constants (MODE_CONT=1'b0, MODE_BURST=1'b1) and the channel state encoding (IDLE, RUN_HI, RUN_LO).
- Sub-module blink_channel implements one channel (FSM, counter, remaining count). The top is a generate loop of NUM_CH instances plus bus slicing.

## Test plan
- Reset mid-run: H=3, continuous, then i_rst pulsed for 1 cycle → all outputs 0 on the next edge, and o_toggle rises again 3 cycles after i_rst falls.
- Continuous, ch0, H=4 → o_toggle period 8, first rise 4 cycles after enable, o_done stays 0. Then drop i_enable mid-high → o_toggle=0 next cycle.
- Burst, ch1, H=2, N=3, start at cycle 10 → high on cycles 11–12, 15–16 and 19–20; o_done only on cycle 21; o_busy covers 11–20.
- Edge cases: H=0 behaves as H=1 (toggle every cycle); N=0 gives a single 1-pulse burst; i_start while busy is ignored (pulse count unchanged).
- Abort: burst N=2, drop i_enable during the second high phase → no o_done, o_busy=0 next cycle. A back-to-back start on the o_done cycle produces a new burst with no gap.
- Independence: four channels with different H, N and modes run concurrently → each matches its standalone golden model cycle-for-cycle.
